shift_reg_sequencer: RTL and testbench
======================================

Name: shift_reg_sequencer

Overview:
- Command-driven controller placed directly upstream of the team's 8-bit load/shift-left-right register.
- Accepts a command {data, direction, shift count} over a valid/ready handshake.
- Drives the register's parallel input, load/shift-enable and direction pins so the register loads the data, then shifts it exactly N times.
- Reads the register output back, publishes it as a one-cycle result, and flags any mismatch against an internally computed expected value.
- Between commands it holds the register's value by reloading it every cycle, because the register has no hold mode.

Parameters:
- WIDTH, 8, data width; must match the shift register width.
- CNT_W, $clog2(WIDTH+1), width of the shift-count field (4 for WIDTH=8).

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command this cycle.
- cmd_data  input  WIDTH  value to load into the shift register.
- cmd_dir  input  1  0 = shift left, 1 = shift right (same encoding as the register).
- cmd_count  input  CNT_W  number of shifts, 0..WIDTH; values above WIDTH are clamped to WIDTH.
- sr_i  output  WIDTH  to register parallel input.
- sr_load_enable  output  1  to register: 1 = load, 0 = shift.
- sr_shift_left_right  output  1  to register direction input.
- sr_q  input  WIDTH  from register output.
- res_valid  output  1  one-cycle pulse, result available.
- res_data  output  WIDTH  captured register value after shifting.
- res_error  output  1  valid with res_valid: 1 = sr_q differed from expected.
- busy  output  1  command in progress (state != IDLE).

Behaviour:
- Reset is asynchronous on reset_n low. On reset:
  - State goes to IDLE; count, expected and hold registers clear to 0.
  - res_valid, res_data, res_error and busy go to 0.
  - sr_i goes to 0, sr_load_enable to 1, sr_shift_left_right to 0, cmd_ready to 1.
- States are IDLE, LOAD, SHIFT and CAPTURE. All sr_* outputs, cmd_ready and busy are decoded from state and registers, with no combinational path from cmd_* inputs.
- IDLE:
  - Outputs: cmd_ready=1, sr_load_enable=1, sr_i=hold (last res_data) so the register keeps its value.
  - Acceptance: a command is taken when cmd_valid && cmd_ready at an edge.
  - On acceptance the block latches data, dir, clamped count, and expected = dir ? data>>count : data<<count (zero fill; count=WIDTH gives 0), then goes to LOAD.
- LOAD (1 cycle):
  - Outputs: sr_load_enable=1, sr_i=latched data, cmd_ready=0.
  - Next state: SHIFT if count>0, else CAPTURE.
- SHIFT:
  - Outputs: sr_load_enable=0, sr_shift_left_right=latched dir, sr_i=latched data (don't-care to the register).
  - Counting: the remaining count decrements each edge. At the edge where remaining==1 the state goes to CAPTURE.
  - Exactly count shift cycles are issued.
- CAPTURE (1 cycle):
  - Outputs: sr_load_enable=1, sr_i=sr_q, so the register holds its value.
  - At the edge: res_data<=sr_q, hold<=sr_q, res_error<=(sr_q!=expected), res_valid<=1, then go to IDLE.
- res_valid is high for exactly one cycle. res_data and res_error keep their values until the next capture. res_error is meaningful only when res_valid=1.
- Latency: with acceptance at edge E0, res_valid is high in the cycle after edge E0+count+2, i.e. count+3 cycles after acceptance.
- Back-to-back commands: a command may be accepted in the same cycle res_valid is high, since the state is IDLE then.
- cmd_ready is 0 in LOAD/SHIFT/CAPTURE. Commands presented then are not accepted and must be held by the source.
- Reset mid-command: the state aborts immediately to IDLE, no res_valid is produced, and the partial command is discarded.

Test Plan:
- Reset then idle: reset_n low 3 cycles, release, idle 5 cycles -> cmd_ready=1, busy=0, res_valid=0, sr_load_enable=1, sr_i=0 every cycle.
- Left shift: cmd_data=8'b1011_0011, dir=0, count=3 -> res_valid exactly 6 cycles after acceptance, res_data=8'b1001_1000, res_error=0; register holds 8'b1001_1000 for 10 further idle cycles.
- Right shift, full and zero count:
  - data=8'hFF, dir=1, count=8 -> res_data=8'h00.
  - count=0, data=8'h5A -> res_data=8'h5A with res_valid 3 cycles after acceptance.
  - count=12 is clamped and behaves as count=8.
- Back-to-back with backpressure: hold cmd_valid with a second command (8'h81, dir=1, count=1) during the first command -> it is accepted in the res_valid cycle of the first command and yields res_data=8'h40.
- Fault injection: force sr_q bit 0 stuck-at-1 in the bench for the left-shift command 8'h01, count=2 -> res_data=8'h05, res_error=1.
- Reset mid-SHIFT: assert reset_n during the 2nd shift of a count=5 command -> outputs return to reset values within the same cycle, no res_valid pulse, and a new command afterwards completes normally.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: command-driven controller for the 8-bit load/shift
// register. It loads the command data, issues exactly N shifts, then reads the
// register back, reports the value and flags a mismatch against the expected
// result. While idle it reloads the last captured value every cycle, because
// the register has no hold mode.
module shift_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] sr_i,
  output logic             sr_load_enable,
  output logic             sr_shift_left_right,
  input  logic [WIDTH-1:0] sr_q,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_error,
  output logic             busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             dir;
  } cmd_t;

  logic [1:0]       state;
  cmd_t             cmd_q;
  logic [CNT_W-1:0] cnt_q;    // shifts still to issue
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] hold_q;   // value re-loaded into the register while idle

  logic [CNT_W-1:0] cnt_clamp;
  logic [WIDTH-1:0] exp_calc;

  // Clamp the shift count and precompute the zero-filled expected result.
  always_comb begin
    cnt_clamp = (cmd_count > CNT_MAX) ? CNT_MAX : cmd_count;
    exp_calc  = cmd_dir ? (cmd_data >> cnt_clamp) : (cmd_data << cnt_clamp);
  end

  // Sequencer state, command latches and result capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      hold_q    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_error <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_ready is 1 throughout IDLE, so cmd_valid alone accepts
          if (cmd_valid) begin
            cmd_q.data <= cmd_data;
            cmd_q.dir  <= cmd_dir;
            cnt_q      <= cnt_clamp;
            exp_q      <= exp_calc;
            state      <= LOAD;
          end
        end
        LOAD:
          state <= (cnt_q != '0) ? SHIFT : CAPTURE;
        SHIFT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          res_data  <= sr_q;
          hold_q    <= sr_q;
          res_error <= (sr_q != exp_q);
          res_valid <= 1'b1;
          state     <= IDLE;
        end
        default:
          state <= IDLE;
      endcase
    end
  end

  // Register drive decoded from state only; no path from cmd_* inputs.
  always_comb begin
    sr_i = hold_q;
    case (state)
      LOAD, SHIFT: sr_i = cmd_q.data;
      CAPTURE:     sr_i = sr_q;     // reload the shifted value so it holds
      default:     sr_i = hold_q;
    endcase
  end

  assign sr_load_enable      = (state != SHIFT);
  assign sr_shift_left_right = cmd_q.dir;
  assign cmd_ready           = (state == IDLE);
  assign busy                = (state != IDLE);

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer. Includes a behavioural model of the
// 8-bit load/shift register fed by the sequencer, with a stuck-at-1 option on
// bit 0 of its output for fault injection.
module tb_shift_reg_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic [W-1:0]  sr_i;
  logic          sr_load_enable;
  logic          sr_shift_left_right;
  logic [W-1:0]  sr_q;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          res_error;
  logic          busy;

  logic [W-1:0]  reg_q = '0;
  logic          stuck = 1'b0;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  shift_reg_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .sr_i(sr_i), .sr_load_enable(sr_load_enable),
    .sr_shift_left_right(sr_shift_left_right), .sr_q(sr_q),
    .res_valid(res_valid), .res_data(res_data), .res_error(res_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External register model: load, or shift with zero fill.
  always @(posedge clk) begin
    if (sr_load_enable)           reg_q <= sr_i;
    else if (sr_shift_left_right) reg_q <= reg_q >> 1;
    else                          reg_q <= reg_q << 1;
  end

  assign sr_q = reg_q | {{(W-1){1'b0}}, stuck};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [W-1:0] hold);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rvalid"}, res_valid, 0);
    chk({tag, "_ld"}, sr_load_enable, 1);
    chk({tag, "_sri"}, sr_i, hold);
  endtask

  // Present a command and return one cycle after the accepting edge.
  task automatic accept(input logic [W-1:0] d, input logic dir, input logic [CW-1:0] c);
    cmd_data = d; cmd_dir = dir; cmd_count = c; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) break;
      step();
    end
    chk("accept_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Latency in cycles, the cycle right after the accepting edge being 1.
  task automatic wait_res(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (res_valid) begin
        lat = n + 1;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] d, input logic dir,
                     input logic [CW-1:0] c, input logic [W-1:0] exp_d,
                     input logic exp_e, input int exp_lat);
    int lat;
    accept(d, dir, c);
    wait_res(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, res_data, exp_d);
    chk({tag, "_err"}, res_error, exp_e);
    step();
    chk({tag, "_pulse"}, res_valid, 0);
  endtask

  initial begin
    int lat;
    int pulses;

    // Reset held 3 cycles, then 5 idle cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("rst", 8'h00);
      chk("rst_dir", sr_shift_left_right, 0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle("idle", 8'h00);
    end

    // Left shift 1011_0011 by 3 -> 1001_1000, then the register must hold it
    run("left3", 8'b1011_0011, 1'b0, 4'd3, 8'b1001_1000, 1'b0, 6);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_reg", reg_q, 8'h98);
      chk_idle("hold", 8'h98);
    end

    // Right shift full, zero count, clamped count
    run("right8", 8'hFF, 1'b1, 4'd8, 8'h00, 1'b0, 11);
    run("cnt0", 8'h5A, 1'b1, 4'd0, 8'h5A, 1'b0, 3);
    run("clamp12", 8'hC3, 1'b0, 4'd12, 8'h00, 1'b0, 11);
    run("right3", 8'hC3, 1'b1, 4'd3, 8'h18, 1'b0, 6);

    // Back-to-back: second command held during the first
    accept(8'b1011_0011, 1'b0, 4'd3);
    cmd_data = 8'h81; cmd_dir = 1'b1; cmd_count = 4'd1; cmd_valid = 1'b1;
    chk("b2b_busy_ready", cmd_ready, 0);
    wait_res(lat);
    chk("b2b_first_lat", lat, 6);
    chk("b2b_first_data", res_data, 8'h98);
    chk("b2b_ready_in_res", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("b2b_second_busy", busy, 1);
    wait_res(lat);
    chk("b2b_second_lat", lat, 4);
    chk("b2b_second_data", res_data, 8'h40);
    chk("b2b_second_err", res_error, 0);

    // Fault injection: sr_q bit 0 stuck at 1
    step();
    stuck = 1'b1;
    run("fault", 8'h01, 1'b0, 4'd2, 8'h05, 1'b1, 5);
    stuck = 1'b0;
    step();

    // Reset during the 2nd shift of a count=5 command
    accept(8'hA5, 1'b0, 4'd5);
    step();
    step();
    chk("mid_busy", busy, 1);
    chk("mid_shift", sr_load_enable, 0);
    reset_n = 1'b0;
    #1;
    chk_idle("mid_rst", 8'h00);
    chk("mid_rst_dir", sr_shift_left_right, 0);
    chk("mid_rst_rdata", res_data, 8'h00);
    chk("mid_rst_rerr", res_error, 0);
    step();
    step();
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (res_valid) pulses++;
    end
    chk("mid_no_pulse", pulses, 0);
    run("after_rst", 8'h3C, 1'b0, 4'd2, 8'hF0, 1'b0, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time limit so the bench always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
